hyper_cordic_ctrl: RTL and testbench

- Iterative sequencer for the hyperbolic CORDIC shift-add datapath.
- Operand format: signed Q11.4, 16 bits (1 sign, 11 integer, 4 fraction).
- Per operation: accepts one request, range-checks the angle, loads the datapath, then steps it through the hyperbolic iteration schedule, including the mandatory repeats at shifts 4 and 13.
- Drives per-step shift/atanh index and rotation direction from datapath sign feedback; presents a held result-valid to the consumer.

---
 rtl/hyper_cordic_ctrl.sv | 131 +++++++++++++
 tb/tb_hyper_cordic_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_cordic_ctrl.sv
// Iteration sequencer for a hyperbolic CORDIC shift-add datapath: accepts a request,
// range-checks the angle, loads the datapath, then walks the repeat-at-4/13 shift schedule.
module hyper_cordic_ctrl #(
  parameter int IDWIDTH = 16,
  parameter int N_ITER  = 8,
  parameter int Z_LIMIT = 17
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iValid,
  output logic               oReady,
  input  logic               iMode,
  input  logic [IDWIDTH-1:0] iZ,
  output logic               oLoad,
  output logic               oIterEn,
  output logic [3:0]         oShift,
  output logic               oDir,
  input  logic               iZSign,
  input  logic               iYSign,
  output logic [3:0]         oStep,
  output logic               oValid,
  output logic               oErr,
  input  logic               iOutReady
);

  localparam int N_STEPS = N_ITER + ((N_ITER >= 4) ? 1 : 0) + ((N_ITER >= 13) ? 1 : 0);
  localparam logic [4:0] LAST_STEP = 5'(N_STEPS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         step_q, step_d;
  logic [3:0]         shift_q, shift_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic               load_q, load_d;
  logic               iter_en_q, iter_en_d;
  logic               valid_q, valid_d;
  logic               err_out_q, err_out_d;
  logic [IDWIDTH-1:0] z_abs;
  logic               z_oor;

  // Step index to shift amount: shifts 4 and 13 each occupy two consecutive steps.
  function automatic logic [3:0] shift_of(input logic [4:0] step);
    logic [4:0] s;
    s = step + 5'd1;
    if (N_ITER >= 4 && step >= 5'd4) s = s - 5'd1;
    if (N_ITER >= 13 && step >= 5'd14) s = s - 5'd1;
    return s[3:0];
  endfunction

  // The most-negative code has no positive twin, so it is flagged explicitly.
  assign z_abs = iZ[IDWIDTH-1] ? (~iZ + IDWIDTH'(1)) : iZ;
  assign z_oor = (iZ == {1'b1, {(IDWIDTH-1){1'b0}}}) || (z_abs > IDWIDTH'(Z_LIMIT));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mode_d  = mode_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        step_d = 5'd0;
        if (iValid) begin
          mode_d  = iMode;
          err_d   = ~iMode & z_oor;
          state_d = LOAD;
        end
      end
      // A rejected angle still spends this cycle here (without oLoad) before reporting.
      LOAD: begin
        step_d  = 5'd0;
        state_d = err_q ? DONE : ITER;
      end
      ITER: begin
        if (step_q == LAST_STEP) begin
          step_d  = 5'd0;
          state_d = DONE;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      DONE: begin
        if (iOutReady) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    shift_d   = shift_of(step_d);
    load_d    = (state_d == LOAD) & ~err_d;
    iter_en_d = (state_d == ITER);
    valid_d   = (state_d == DONE);
    err_out_d = (state_d == DONE) & err_d;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      step_q    <= 5'd0;
      shift_q   <= 4'd1;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      iter_en_q <= 1'b0;
      valid_q   <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      shift_q   <= shift_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      load_q    <= load_d;
      iter_en_q <= iter_en_d;
      valid_q   <= valid_d;
      err_out_q <= err_out_d;
    end
  end

  assign oReady  = (state_q == IDLE);
  assign oLoad   = load_q;
  assign oIterEn = iter_en_q;
  assign oShift  = shift_q;
  assign oStep   = step_q[3:0];
  assign oValid  = valid_q;
  assign oErr    = err_out_q;
  assign oDir    = iter_en_q & (mode_q ? iYSign : ~iZSign);

endmodule

// File: tb/tb_hyper_cordic_ctrl.sv
// Testbench for hyper_cordic_ctrl: two builds (N_ITER=8 and N_ITER=14) share one stimulus
// stream and are checked every cycle against a time-since-accept behavioural model.
module tb_hyper_cordic_ctrl;

   localparam int ZLIMIT = 17;

   logic        iClk = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iValid = 1'b0;
   logic        iMode = 1'b0;
   logic [15:0] iZ = 16'h0000;
   logic        iZSign = 1'b0;
   logic        iYSign = 1'b0;
   logic        iOutReady = 1'b1;

   logic        rdy [2];
   logic        ld  [2];
   logic        it  [2];
   logic        dr  [2];
   logic        vl  [2];
   logic        er  [2];
   logic [3:0]  sh  [2];
   logic [3:0]  st  [2];

   int checks = 0;
   int errors = 0;

   // Reference model state per build: busy flag, cycles since accept, latched mode/error.
   int nIter [2] = '{8, 14};
   int sched [2][$];
   int ns    [2];
   bit busy  [2] = '{1'b0, 1'b0};
   int tAcc  [2] = '{0, 0};
   bit mMode [2] = '{1'b0, 1'b0};
   bit mErr  [2] = '{1'b0, 1'b0};

   // Observation logs used by the directed scenarios.
   int shLog   [2][$];
   int loadCnt [2] = '{0, 0};

   int seqA [9]  = '{1, 2, 3, 4, 4, 5, 6, 7, 8};
   int seqB [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

   // Free-running clock, 10 time-unit period.
   always #5 iClk = ~iClk;

   hyper_cordic_ctrl #(.IDWIDTH(16), .N_ITER(8), .Z_LIMIT(17)) dut0 (
      .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(rdy[0]), .iMode(iMode), .iZ(iZ),
      .oLoad(ld[0]), .oIterEn(it[0]), .oShift(sh[0]), .oDir(dr[0]), .iZSign(iZSign),
      .iYSign(iYSign), .oStep(st[0]), .oValid(vl[0]), .oErr(er[0]), .iOutReady(iOutReady));

   hyper_cordic_ctrl #(.IDWIDTH(16), .N_ITER(14), .Z_LIMIT(17)) dut1 (
      .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(rdy[1]), .iMode(iMode), .iZ(iZ),
      .oLoad(ld[1]), .oIterEn(it[1]), .oShift(sh[1]), .oDir(dr[1]), .iZSign(iZSign),
      .iYSign(iYSign), .oStep(st[1]), .oValid(vl[1]), .oErr(er[1]), .iOutReady(iOutReady));

   // An angle is rejected only in rotation mode, when its magnitude exceeds the limit
   // or it is the most-negative code.
   function automatic bit calcErr(input bit m, input logic [15:0] z);
      int zi;
      zi = int'($signed(z));
      return !m && (z == 16'h8000 || zi > ZLIMIT || zi < -ZLIMIT);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit v, input bit m, input logic [15:0] z,
                                input bit ys, input bit zs, input bit ordy);
      iValid    = v;
      iMode     = m;
      iZ        = z;
      iYSign    = ys;
      iZSign    = zs;
      iOutReady = ordy;
   endtask

   // Advance to just after the next rising edge so inputs never change on the edge.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Model update: an accept starts the timeline, a handshake in the result phase ends it.
   always @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         busy <= '{1'b0, 1'b0};
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (!busy[d]) begin
               if (iValid) begin
                  busy[d]  <= 1'b1;
                  tAcc[d]  <= 0;
                  mMode[d] <= iMode;
                  mErr[d]  <= calcErr(iMode, iZ);
               end
            end else if (tAcc[d] >= (mErr[d] ? 1 : ns[d] + 1) && iOutReady) begin
               busy[d] <= 1'b0;
            end else begin
               tAcc[d] <= tAcc[d] + 1;
            end
         end
      end
   end

   task automatic checkReset(input int d, input string tag);
      checkOutput($sformatf("%s_d%0d_ready", tag, d), int'(rdy[d]), 1);
      checkOutput($sformatf("%s_d%0d_load", tag, d), int'(ld[d]), 0);
      checkOutput($sformatf("%s_d%0d_iter", tag, d), int'(it[d]), 0);
      checkOutput($sformatf("%s_d%0d_valid", tag, d), int'(vl[d]), 0);
      checkOutput($sformatf("%s_d%0d_err", tag, d), int'(er[d]), 0);
      checkOutput($sformatf("%s_d%0d_dir", tag, d), int'(dr[d]), 0);
      checkOutput($sformatf("%s_d%0d_shift", tag, d), int'(sh[d]), 1);
      checkOutput($sformatf("%s_d%0d_step", tag, d), int'(st[d]), 0);
   endtask

   // Expected outputs follow from the time since accept: one load cycle, ns[d] iteration
   // cycles, then a held result; a rejected angle skips straight to the result one cycle later.
   task automatic compareDut(input int d);
      bit eLoad, eIter, eValid, eDir;
      if (!iRst_n) begin
         checkReset(d, "rst");
      end else begin
         eLoad  = busy[d] && tAcc[d] == 0 && !mErr[d];
         eIter  = busy[d] && !mErr[d] && tAcc[d] >= 1 && tAcc[d] <= ns[d];
         eValid = busy[d] && tAcc[d] >= (mErr[d] ? 1 : ns[d] + 1);
         eDir   = eIter ? (mMode[d] ? iYSign : !iZSign) : 1'b0;
         checkOutput($sformatf("d%0d_ready", d), int'(rdy[d]), int'(!busy[d]));
         checkOutput($sformatf("d%0d_load", d), int'(ld[d]), int'(eLoad));
         checkOutput($sformatf("d%0d_iter", d), int'(it[d]), int'(eIter));
         checkOutput($sformatf("d%0d_valid", d), int'(vl[d]), int'(eValid));
         checkOutput($sformatf("d%0d_dir", d), int'(dr[d]), int'(eDir));
         if (eIter) begin
            checkOutput($sformatf("d%0d_shift", d), int'(sh[d]), sched[d][tAcc[d] - 1]);
            checkOutput($sformatf("d%0d_step", d), int'(st[d]), tAcc[d] - 1);
         end
         if (eValid) begin
            checkOutput($sformatf("d%0d_oerr", d), int'(er[d]), int'(mErr[d]));
         end
      end
      if (it[d] === 1'b1) shLog[d].push_back(int'(sh[d]));
      if (ld[d] === 1'b1) loadCnt[d]++;
   endtask

   // Compare process: every falling edge, both builds against the model.
   always @(negedge iClk) begin
      for (int d = 0; d < 2; d++) compareDut(d);
   end

   task automatic waitIdle();
      int n;
      iValid    = 1'b0;
      iOutReady = 1'b1;
      n = 0;
      while (!(rdy[0] && rdy[1]) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) checkOutput("wait_idle_timeout", 0, 1);
   endtask

   // One isolated operation with literal latency, error and schedule expectations.
   task automatic runOp(input bit m, input logic [15:0] z, input bit expErr, input string tag);
      int k;
      int lat [2];
      int errSeen [2];
      waitIdle();
      for (int d = 0; d < 2; d++) begin
         shLog[d].delete();
         loadCnt[d] = 0;
      end
      applyStimulus(1'b1, m, z, 1'($urandom), 1'($urandom), 1'b1);
      tick();
      iValid = 1'b0;
      lat = '{-1, -1};
      errSeen = '{-1, -1};
      k = 0;
      while ((lat[0] < 0 || lat[1] < 0) && k < 40) begin
         for (int d = 0; d < 2; d++) begin
            if (lat[d] < 0 && vl[d]) begin
               lat[d] = k;
               errSeen[d] = int'(er[d]);
            end
         end
         iYSign = 1'($urandom);
         iZSign = 1'($urandom);
         tick();
         k++;
      end
      checkOutput({tag, "_d0_latency"}, lat[0], expErr ? 1 : 10);
      checkOutput({tag, "_d1_latency"}, lat[1], expErr ? 1 : 17);
      checkOutput({tag, "_d0_err"}, errSeen[0], int'(expErr));
      checkOutput({tag, "_d1_err"}, errSeen[1], int'(expErr));
      checkOutput({tag, "_d0_loads"}, loadCnt[0], expErr ? 0 : 1);
      checkOutput({tag, "_d1_loads"}, loadCnt[1], expErr ? 0 : 1);
      checkOutput({tag, "_d0_steps"}, shLog[0].size(), expErr ? 0 : 9);
      checkOutput({tag, "_d1_steps"}, shLog[1].size(), expErr ? 0 : 16);
      if (!expErr) begin
         for (int i = 0; i < 9 && i < shLog[0].size(); i++)
            checkOutput($sformatf("%s_d0_shift%0d", tag, i), shLog[0][i], seqA[i]);
         for (int i = 0; i < 16 && i < shLog[1].size(); i++)
            checkOutput($sformatf("%s_d1_shift%0d", tag, i), shLog[1][i], seqB[i]);
      end
   endtask

   // Result held under backpressure while a request waits; it is taken one cycle after release.
   task automatic backpressure();
      int n;
      waitIdle();
      applyStimulus(1'b1, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (!vl[0] && n < 40) begin
         tick();
         n++;
      end
      checkOutput("bp_valid_reached", int'(vl[0]), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("bp_hold_valid%0d", i), int'(vl[0]), 1);
         checkOutput($sformatf("bp_hold_err%0d", i), int'(er[0]), 0);
         checkOutput($sformatf("bp_hold_ready%0d", i), int'(rdy[0]), 0);
      end
      iOutReady = 1'b1;
      tick();
      checkOutput("bp_after_hs_ready", int'(rdy[0]), 1);
      checkOutput("bp_after_hs_valid", int'(vl[0]), 0);
      checkOutput("bp_after_hs_load", int'(ld[0]), 0);
      tick();
      checkOutput("bp_accept_load", int'(ld[0]), 1);
      checkOutput("bp_accept_ready", int'(rdy[0]), 0);
      waitIdle();
   endtask

   // Asynchronous reset at iteration step 4 clears every output immediately.
   task automatic midReset();
      int n;
      waitIdle();
      applyStimulus(1'b1, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1);
      tick();
      iValid = 1'b0;
      n = 0;
      while (!(it[0] && st[0] == 4'd4) && n < 40) begin
         tick();
         n++;
      end
      checkOutput("rst_reached_step4", int'(st[0]), 4);
      #2;
      iRst_n = 1'b0;
      #1;
      checkReset(0, "midrst");
      checkReset(1, "midrst");
      @(posedge iClk);
      @(posedge iClk);
      #3;
      iRst_n = 1'b1;
      runOp(1'b0, 16'h0008, 1'b0, "post_rst");
   endtask

   // Random traffic mixing modes, edge-case angles, sign feedback and backpressure.
   task automatic randomPhase(input int cycles);
      logic [15:0] z;
      int zi;
      for (int c = 0; c < cycles; c++) begin
         case ($urandom_range(0, 4))
            0: begin zi = int'($urandom_range(0, 40)) - 20; z = 16'(zi); end
            1: z = 16'h8000;
            2: begin
                  case ($urandom_range(0, 3))
                     0: z = 16'd17;
                     1: z = 16'd18;
                     2: z = 16'hFFEF;
                     default: z = 16'hFFEE;
                  endcase
               end
            3: z = 16'($urandom);
            default: z = 16'h0008;
         endcase
         applyStimulus(1'($urandom), 1'($urandom), z, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 9) < 7);
         tick();
      end
   endtask

   // Main sequence: reset, directed scenarios, random traffic, summary.
   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int s = 1; s <= nIter[d]; s++) begin
            sched[d].push_back(s);
            if (s == 4 || s == 13) sched[d].push_back(s);
         end
         ns[d] = sched[d].size();
      end
      repeat (3) @(posedge iClk);
      #1;
      iRst_n = 1'b1;
      tick();
      $display("[TB] reset released");

      runOp(1'b0, 16'h0008, 1'b0, "rot_8");
      runOp(1'b0, 16'h0012, 1'b1, "rot_18");
      runOp(1'b0, 16'hFFEF, 1'b0, "rot_m17");
      runOp(1'b0, 16'h0011, 1'b0, "rot_17");
      runOp(1'b0, 16'hFFEE, 1'b1, "rot_m18");
      runOp(1'b0, 16'h8000, 1'b1, "rot_min");
      runOp(1'b1, 16'h8000, 1'b0, "vec_min");
      runOp(1'b1, 16'h7FFF, 1'b0, "vec_big");
      backpressure();
      midReset();
      $display("[TB] directed scenarios complete");

      randomPhase(3000);
      waitIdle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
